// File: rtl/icesoc_bus_pkg.sv
// Shared bus definitions for the SoC interconnect bridges: FSM encoding,
// default timeout read data and the decode window width/compare helper.
package icesoc_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_ACK  = 2'd3
   } bridge_state_e;

   localparam logic [31:0] TIMEOUT_DATA_DEFAULT = 32'hDEAD_BEEF;
   localparam int          WIN_ADDR_WIDTH       = 12;

   // True when adr falls in the window whose base is compared on bits [31:aw].
   function automatic logic in_window(input logic [31:0] adr,
                                      input logic [31:0] base,
                                      input int          aw);
      return (adr >> aw) == (base >> aw);
   endfunction

endpackage

// File: rtl/wb_master_bridge_if.sv
// Wishbone classic slave port plus interconnect master port of the bridge.
// 'master' is the bridge's view, 'slave' is the view of everything around it.
interface wb_master_bridge_if #(
   parameter int ADDR_WIDTH = icesoc_bus_pkg::WIN_ADDR_WIDTH
);
   logic                  wbs_stb_i;
   logic                  wbs_cyc_i;
   logic                  wbs_we_i;
   logic [3:0]            wbs_sel_i;
   logic [31:0]           wbs_adr_i;
   logic [31:0]           wbs_dat_i;
   logic                  wbs_ack_o;
   logic [31:0]           wbs_dat_o;

   logic                  data_req_o;
   logic [ADDR_WIDTH-1:0] data_addr_o;
   logic                  data_we_o;
   logic [3:0]            data_be_o;
   logic [31:0]           data_wdata_o;
   logic                  data_gnt_i;
   logic                  data_rvalid_i;
   logic [31:0]           data_rdata_i;

   modport master (
      input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      output wbs_ack_o, wbs_dat_o,
      output data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
      input  data_gnt_i, data_rvalid_i, data_rdata_i
   );

   modport slave (
      output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      input  wbs_ack_o, wbs_dat_o,
      input  data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
      output data_gnt_i, data_rvalid_i, data_rdata_i
   );
endinterface

// File: rtl/wb_master_bridge.sv
// Wishbone classic slave to interconnect master bridge with per-access
// response timeout, sticky timeout flag and saturating timeout counter.
module wb_master_bridge
   import icesoc_bus_pkg::*;
#(
   parameter int          ADDR_WIDTH     = WIN_ADDR_WIDTH,
   parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
   parameter int          TIMEOUT_CYCLES = 255,
   parameter logic [31:0] TIMEOUT_DATA   = TIMEOUT_DATA_DEFAULT
) (
   input  logic               wb_clk_i,
   input  logic               wb_rst_i,
   wb_master_bridge_if.master bus,
   output logic               timeout_o,
   output logic [7:0]         timeout_count_o
);

   // WAIT lasts at most TIMEOUT_CYCLES cycles; counter starts at 0 on entry.
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

   bridge_state_e state;
   logic [7:0]    wait_cnt;
   logic          cyc_lost;
   logic          hit;
   logic          ack_ok;

   assign hit    = bus.wbs_stb_i && bus.wbs_cyc_i &&
                   in_window(bus.wbs_adr_i, BASE_ADDR, ADDR_WIDTH);
   // Master must have held cyc through the whole access to see the ack.
   assign ack_ok = !cyc_lost && bus.wbs_cyc_i;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state            <= ST_IDLE;
         wait_cnt         <= '0;
         cyc_lost         <= 1'b0;
         bus.wbs_ack_o    <= 1'b0;
         bus.wbs_dat_o    <= '0;
         bus.data_req_o   <= 1'b0;
         bus.data_addr_o  <= '0;
         bus.data_we_o    <= 1'b0;
         bus.data_be_o    <= '0;
         bus.data_wdata_o <= '0;
         timeout_o        <= 1'b0;
         timeout_count_o  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               bus.wbs_ack_o <= 1'b0;
               if (hit) begin
                  bus.data_addr_o  <= {bus.wbs_adr_i[ADDR_WIDTH-1:2], 2'b00};
                  bus.data_we_o    <= bus.wbs_we_i;
                  bus.data_be_o    <= bus.wbs_sel_i;
                  bus.data_wdata_o <= bus.wbs_dat_i;
                  cyc_lost         <= 1'b0;
                  // A write touching no bytes has nothing to send downstream.
                  if (bus.wbs_we_i && bus.wbs_sel_i == 4'b0000) begin
                     bus.wbs_ack_o <= 1'b1;
                     state         <= ST_ACK;
                  end else begin
                     bus.data_req_o <= 1'b1;
                     state          <= ST_REQ;
                  end
               end
            end
            ST_REQ: begin
               if (!bus.wbs_cyc_i) cyc_lost <= 1'b1;
               if (bus.data_gnt_i) begin
                  bus.data_req_o <= 1'b0;
                  if (bus.data_rvalid_i) begin
                     if (!bus.data_we_o) bus.wbs_dat_o <= bus.data_rdata_i;
                     bus.wbs_ack_o <= ack_ok;
                     state         <= ST_ACK;
                  end else begin
                     wait_cnt <= '0;
                     state    <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               if (!bus.wbs_cyc_i) cyc_lost <= 1'b1;
               wait_cnt <= wait_cnt + 8'd1;
               if (bus.data_rvalid_i) begin
                  if (!bus.data_we_o) bus.wbs_dat_o <= bus.data_rdata_i;
                  bus.wbs_ack_o <= ack_ok;
                  state         <= ST_ACK;
               end else if (wait_cnt == WAIT_LAST) begin
                  bus.wbs_dat_o <= TIMEOUT_DATA;
                  timeout_o     <= 1'b1;
                  if (timeout_count_o != 8'hFF)
                     timeout_count_o <= timeout_count_o + 8'd1;
                  bus.wbs_ack_o <= ack_ok;
                  state         <= ST_ACK;
               end
            end
            ST_ACK: begin
               bus.wbs_ack_o <= 1'b0;
               state         <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
